// File: rtl/lc3b_types.sv
// Shared L2 types: default LRU array geometry and the index/way typedefs sized from it.
package lc3b_types;

    localparam int unsigned L2_LRU_SETS = 16;
    localparam int unsigned L2_LRU_WAYS = 4;

    typedef logic [$clog2(L2_LRU_SETS)-1:0] lc3b_c_l2_index;
    typedef logic [$clog2(L2_LRU_WAYS)-1:0] lc3b_l2_way;

endpackage

// File: rtl/lru_age_set.sv
// One set of true-LRU age state. Ages form a permutation of 0..NUM_WAYS-1, 0 = MRU.
// Outputs the LRU/MRU ways of the post-update (next) ages so a same-cycle read sees them.
// Optional invalidate logic is built when L2_LRU_INVAL_EN is defined.
module lru_age_set #(
    parameter int unsigned NUM_WAYS = 4,
    localparam int unsigned WAY_W   = $clog2(NUM_WAYS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             touch,
    input  logic [WAY_W-1:0] touch_way,
`ifdef L2_LRU_INVAL_EN
    input  logic             inval,
    input  logic [WAY_W-1:0] inval_way,
`endif
    output logic [WAY_W-1:0] lru_way,
    output logic [WAY_W-1:0] mru_way
);

    localparam logic [WAY_W-1:0] AgeLru = WAY_W'(NUM_WAYS - 1);

    logic [NUM_WAYS-1:0][WAY_W-1:0] age_q, age_t, age_d;
    logic [WAY_W-1:0]               touch_age;
`ifdef L2_LRU_INVAL_EN
    logic [WAY_W-1:0]               inval_age;
`endif

    // Next-state: touch first, then invalidate on the touched result.
    always_comb begin
        age_t     = age_q;
        touch_age = age_q[touch_way];
        if (touch) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (age_q[w] < touch_age) age_t[w] = age_q[w] + 1'b1;
            end
            age_t[touch_way] = '0;
        end
        age_d = age_t;
`ifdef L2_LRU_INVAL_EN
        inval_age = age_t[inval_way];
        if (inval) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (age_t[w] > inval_age) age_d[w] = age_t[w] - 1'b1;
            end
            age_d[inval_way] = AgeLru;
        end
`endif
    end

    // Age registers; reset makes way 0 LRU and way NUM_WAYS-1 MRU.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int w = 0; w < NUM_WAYS; w++) age_q[w] <= WAY_W'(NUM_WAYS - 1 - w);
        end else begin
            age_q <= age_d;
        end
    end

    // Locate LRU and MRU ways in the post-update ages.
    always_comb begin
        lru_way = '0;
        mru_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (age_d[w] == AgeLru) lru_way = WAY_W'(w);
            if (age_d[w] == '0)     mru_way = WAY_W'(w);
        end
    end

endmodule

// File: rtl/l2_lru_array.sv
// L2 true-LRU replacement-state array: NUM_SETS x NUM_WAYS, registered read with
// same-cycle update forwarding. Define L2_LRU_INVAL_EN to add the invalidate ports.
module l2_lru_array
    import lc3b_types::*;
#(
    parameter int unsigned NUM_SETS = L2_LRU_SETS,
    parameter int unsigned NUM_WAYS = L2_LRU_WAYS,
    localparam int unsigned IDX_W   = $clog2(NUM_SETS),
    localparam int unsigned WAY_W   = $clog2(NUM_WAYS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             touch,
    input  logic [IDX_W-1:0] touch_index,
    input  logic [WAY_W-1:0] touch_way,
`ifdef L2_LRU_INVAL_EN
    input  logic             inval,
    input  logic [IDX_W-1:0] inval_index,
    input  logic [WAY_W-1:0] inval_way,
`endif
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_index,
    output logic             rd_valid,
    output logic [WAY_W-1:0] lru_way,
    output logic [WAY_W-1:0] mru_way
);

    logic [NUM_SETS-1:0]             touch_sel;
    logic [NUM_SETS-1:0][WAY_W-1:0]  set_lru, set_mru;
    logic                            rd_valid_q;
    logic [WAY_W-1:0]                lru_q, mru_q;
`ifdef L2_LRU_INVAL_EN
    logic [NUM_SETS-1:0]             inval_sel;
`endif

    for (genvar s = 0; s < NUM_SETS; s++) begin : g_set
        // Set decode for the update requests.
        always_comb begin
            touch_sel[s] = touch && (touch_index == IDX_W'(s));
`ifdef L2_LRU_INVAL_EN
            inval_sel[s] = inval && (inval_index == IDX_W'(s));
`endif
        end

        lru_age_set #(
            .NUM_WAYS (NUM_WAYS)
        ) u_set (
            .clk       (clk),
            .reset     (reset),
            .touch     (touch_sel[s]),
            .touch_way (touch_way),
`ifdef L2_LRU_INVAL_EN
            .inval     (inval_sel[s]),
            .inval_way (inval_way),
`endif
            .lru_way   (set_lru[s]),
            .mru_way   (set_mru[s])
        );
    end

    // Read registers capture the post-update LRU/MRU of the selected set; hold when idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
            lru_q      <= '0;
            mru_q      <= '0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) begin
                lru_q <= set_lru[rd_index];
                mru_q <= set_mru[rd_index];
            end
        end
    end

    assign rd_valid = rd_valid_q;
    assign lru_way  = lru_q;
    assign mru_way  = mru_q;

endmodule
